neo_video_out: RTL

NEO_VIDEO_OUT -- requirements
Module: neo_video_out

---
 rtl/neo_video_out_if.sv | 29 ++
 rtl/neo_video_out.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/neo_video_out_if.sv
// neo_video_out_if -- video-side signal bundle for neo_video_out.
//   master : drives pixel enable, palette word, shadow and raw LSPC syncs;
//            receives the pipelined RGB, delayed syncs, blanking and DE.
//   slave  : the video output block itself.
interface neo_video_out_if;
    logic        CLK_EN_6MB;    // one CLK-cycle pulse per pixel
    logic [15:0] PAL_RAM_DATA;  // {dark, R0, G0, B0, R[4:1], G[4:1], B[4:1]}
    logic        SHADOW;        // halve output intensity
    logic        HSYNC;         // active-low horizontal sync in
    logic        VSYNC;         // active-low vertical sync in
    logic [7:0]  RED;
    logic [7:0]  GREEN;
    logic [7:0]  BLUE;
    logic        HS_OUT;        // active-low, aligned with RGB
    logic        VS_OUT;        // active-low, aligned with RGB
    logic        HBLANK;        // active-high
    logic        VBLANK;        // active-high
    logic        DE;            // ~HBLANK & ~VBLANK

    modport master (
        output CLK_EN_6MB, PAL_RAM_DATA, SHADOW, HSYNC, VSYNC,
        input  RED, GREEN, BLUE, HS_OUT, VS_OUT, HBLANK, VBLANK, DE
    );

    modport slave (
        input  CLK_EN_6MB, PAL_RAM_DATA, SHADOW, HSYNC, VSYNC,
        output RED, GREEN, BLUE, HS_OUT, VS_OUT, HBLANK, VBLANK, DE
    );
endinterface

// File: rtl/neo_video_out.sv
// neo_video_out -- palette-to-RGB conversion and sync/blank timing generator.
// Two pixel-enable stages: stage 1 captures palette word, shadow and raw syncs
// and runs the h/v counters; stage 2 holds converted RGB plus the blanking,
// DE and sync outputs so everything leaves aligned.
// Ports:
//   CLK     : 48 MHz system clock (only clock)
//   nRESET  : asynchronous active-low reset
//   vid     : neo_video_out_if.slave (pixel enable, palette, syncs in; RGB,
//             delayed syncs, blanking, DE out)
module neo_video_out #(
    parameter int unsigned H_START  = 30,   // pixels after HSYNC fall to active
    parameter int unsigned H_ACTIVE = 320,  // active pixels per line
    parameter int unsigned V_START  = 16,   // lines after frame start to active
    parameter int unsigned V_ACTIVE = 224   // active lines per frame
) (
    input  logic            CLK,
    input  logic            nRESET,
    neo_video_out_if.slave  vid
);

    localparam logic [9:0] HBeg = 10'(H_START);
    localparam logic [9:0] HEnd = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] VBeg = 10'(V_START);
    localparam logic [9:0] VEnd = 10'(V_START + V_ACTIVE);

    // Stage 1
    logic [15:0] pal_q;
    logic        shadow_q;
    logic        hs_q, vs_q;
    logic [8:0]  hcnt_q, hcnt_d;
    logic [8:0]  vcnt_q, vcnt_d;
    logic        frame_pend_q, frame_pend_d;

    // Stage 2
    logic [7:0]  red_q, green_q, blue_q;
    logic [7:0]  red_d, green_d, blue_d;
    logic        hs_out_q, vs_out_q;
    logic        hblank_q, vblank_q, de_q;

    logic        hs_fall, vs_fall;
    logic        hblank_raw, vblank_raw, de_raw;

    // 5-bit channel -> 8-bit: extend to 6 bits with the MSB, subtract dark,
    // clamp on underflow, then replicate two bits to fill the byte.
    function automatic logic [7:0] conv_chan(input logic [3:0] hi, input logic lo,
                                             input logic dark, input logic shadow);
        logic [6:0] c6;
        logic [7:0] c8;
        c6 = {1'b0, hi, lo, hi[3]} - {6'b0, dark};
        if (c6[6]) begin
            c8 = 8'h00;
        end else begin
            c8 = {c6[5:0], c6[4:3]};
        end
        return shadow ? {1'b0, c8[7:1]} : c8;
    endfunction

    assign hs_fall = hs_q & ~vid.HSYNC;
    assign vs_fall = vs_q & ~vid.VSYNC;

    // hcnt saturates at 511 so a missing HSYNC parks the line in blanking.
    always_comb begin
        hcnt_d = hcnt_q;
        if (hs_fall) begin
            hcnt_d = '0;
        end else if (hcnt_q != '1) begin
            hcnt_d = hcnt_q + 9'd1;
        end
    end

    // A VSYNC fall arms frame_pend; the next HSYNC fall starts line 0.
    // Coincident falls start the frame immediately.
    always_comb begin
        vcnt_d       = vcnt_q;
        frame_pend_d = frame_pend_q;
        if (hs_fall && vs_fall) begin
            vcnt_d       = '0;
            frame_pend_d = 1'b0;
        end else if (vs_fall) begin
            frame_pend_d = 1'b1;
        end else if (hs_fall) begin
            if (frame_pend_q) begin
                vcnt_d       = '0;
                frame_pend_d = 1'b0;
            end else if (vcnt_q != '1) begin
                vcnt_d = vcnt_q + 9'd1;
            end
        end
    end

    always_comb begin
        hblank_raw = !(({1'b0, hcnt_q} >= HBeg) && ({1'b0, hcnt_q} < HEnd));
        vblank_raw = !(({1'b0, vcnt_q} >= VBeg) && ({1'b0, vcnt_q} < VEnd));
        de_raw     = ~hblank_raw & ~vblank_raw;
        red_d      = 8'h00;
        green_d    = 8'h00;
        blue_d     = 8'h00;
        if (de_raw) begin
            red_d   = conv_chan(pal_q[11:8], pal_q[14], pal_q[15], shadow_q);
            green_d = conv_chan(pal_q[7:4],  pal_q[13], pal_q[15], shadow_q);
            blue_d  = conv_chan(pal_q[3:0],  pal_q[12], pal_q[15], shadow_q);
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            pal_q        <= '0;
            shadow_q     <= 1'b0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            hcnt_q       <= '1;
            vcnt_q       <= '1;
            frame_pend_q <= 1'b0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            hs_out_q     <= 1'b1;
            vs_out_q     <= 1'b1;
            hblank_q     <= 1'b1;
            vblank_q     <= 1'b1;
            de_q         <= 1'b0;
        end else if (vid.CLK_EN_6MB) begin
            pal_q        <= vid.PAL_RAM_DATA;
            shadow_q     <= vid.SHADOW;
            hs_q         <= vid.HSYNC;
            vs_q         <= vid.VSYNC;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            frame_pend_q <= frame_pend_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
            hs_out_q     <= hs_q;
            vs_out_q     <= vs_q;
            hblank_q     <= hblank_raw;
            vblank_q     <= vblank_raw;
            de_q         <= de_raw;
        end
    end

    assign vid.RED    = red_q;
    assign vid.GREEN  = green_q;
    assign vid.BLUE   = blue_q;
    assign vid.HS_OUT = hs_out_q;
    assign vid.VS_OUT = vs_out_q;
    assign vid.HBLANK = hblank_q;
    assign vid.VBLANK = vblank_q;
    assign vid.DE     = de_q;

endmodule
